// File: rtl/memory_8x32_pkg.sv
// Shared widths and FSM state encoding for the 8x32 SRAM controller.
package memory_8x32_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 8;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      RSP,
      CLR
   } ctrl_state_e;

endpackage

// File: rtl/memory_8x32_ctrl_if.sv
// Client-side request, response and bulk-clear channels of the 8x32 SRAM controller.
interface memory_8x32_ctrl_if
   import memory_8x32_pkg::*;
();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              clr_start;
   logic [DATA_W-1:0] clr_data;
   logic              clr_busy;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, clr_start, clr_data, rsp_ready,
      input  req_ready, clr_busy, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, clr_start, clr_data, rsp_ready,
      output req_ready, clr_busy, rsp_valid, rsp_data
   );

endinterface

// File: rtl/memory_8x32_ctrl.sv
// Sole driver of the memory_8x32 SRAM pins: serialises client reads/writes and
// performs a bulk fill of every location on request.
module memory_8x32_ctrl
   import memory_8x32_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   memory_8x32_ctrl_if.slave  bus,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               mem_write_enable,
   output logic [DATA_W-1:0]  mem_write_data,
   input  logic [DATA_W-1:0]  mem_read_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              busy_q, busy_d;

   // A clear request in the same cycle masks the request channel.
   assign bus.req_ready = (state_q == IDLE) && !bus.clr_start;

   assign mem_address      = addr_q;
   assign mem_write_enable = we_q;
   assign mem_write_data   = wdata_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.clr_busy     = busy_q;

   // State and output registers; the SRAM is not reset so an in-flight write still lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic; write enable drops unless a state re-asserts it.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      busy_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.clr_start) begin
               state_d = CLR;
               cnt_d   = '0;
               addr_d  = '0;
               we_d    = 1'b1;
               wdata_d = bus.clr_data;
               busy_d  = 1'b1;
            end else if (bus.req_valid) begin
               addr_d = bus.req_addr;
               if (bus.req_write) begin
                  state_d = WR;
                  wdata_d = bus.req_wdata;
                  we_d    = 1'b1;
               end else begin
                  state_d = RD_ADDR;
               end
            end
         end
         WR:      state_d = IDLE;
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: begin
            rsp_data_d  = mem_read_data;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         CLR: begin
            // Stop after the last location so the counter never wraps.
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
            end else begin
               cnt_d  = ADDR_W'(cnt_q + 1'b1);
               addr_d = ADDR_W'(cnt_q + 1'b1);
               we_d   = 1'b1;
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_memory_8x32_ctrl.sv
// Directed and random bench for memory_8x32_ctrl paired with a behavioural 8x32 SRAM.
module tb_memory_8x32_ctrl;
   import memory_8x32_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   memory_8x32_ctrl_if bus();

   logic [ADDR_W-1:0] mem_address;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   memory_8x32_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus.slave),
      .mem_address      (mem_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   // Behavioural memory_8x32: registered address, write on we, never reset.
   logic [DATA_W-1:0] sram [DEPTH];
   logic [ADDR_W-1:0] sram_addr_q;
   always @(posedge clk) begin
      if (mem_write_enable) sram[mem_address] <= mem_write_data;
      sram_addr_q <= mem_address;
   end
   assign mem_read_data = sram[sram_addr_q];

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;
   logic wr_pend = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write enable may only be high in the cycle after a write accept or while clearing.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         assert (mem_write_enable === (wr_pend | bus.clr_busy)) else begin
            errors++;
            $error("FAIL we_outside_wr_clr: observed %b expected %b",
                   mem_write_enable, wr_pend | bus.clr_busy);
         end
      end
      wr_pend = bus.req_valid & bus.req_ready & bus.req_write & !reset;
   end

   task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output int waited);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      #1;
      while (!bus.req_ready && n < 50) begin
         tick();
         n++;
      end
      check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
      if (wr) ref_mem[a] = d;
      else    exp_q.push_back(ref_mem[a]);
      tick();
      bus.req_valid = 1'b0;
      waited = n;
   endtask

   task automatic get_rsp(input string tag, input int stall);
      int n = 0;
      logic [DATA_W-1:0] exp;
      while (!bus.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd2);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      repeat (stall) tick();
      check({tag, "_data"}, bus.rsp_data, exp);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check({tag, "_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [DATA_W-1:0] exp;
      logic [DATA_W-1:0] rnd;
      logic [ADDR_W-1:0] ra;

      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.clr_start  = 1'b0;
      bus.clr_data   = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check("rst_we",        32'(mem_write_enable), 32'd0);
      check("rst_addr",      32'(mem_address),      32'd0);
      check("rst_wdata",     mem_write_data,        32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid),    32'd0);
      check("rst_rsp_data",  bus.rsp_data,          32'd0);
      check("rst_clr_busy",  32'(bus.clr_busy),     32'd0);
      check("rst_req_ready", 32'(bus.req_ready),    32'd1);
      chk_en = 1'b1;

      // 1: write then read back one location
      send_req(1'b1, 3'd5, 32'hDEADBEEF, n);
      check("t1_wr_addr", 32'(mem_address), 32'd5);
      check("t1_wr_we",   32'(mem_write_enable), 32'd1);
      send_req(1'b0, 3'd5, '0, n);
      check("t1_rd_we", 32'(mem_write_enable), 32'd0);
      get_rsp("t1", 0);

      // 2: back-to-back write then read
      send_req(1'b1, 3'd7, 32'h12345678, n);
      check("t2_ready_low", 32'(bus.req_ready), 32'd0);
      send_req(1'b0, 3'd7, '0, n);
      check("t2_wait", 32'(n), 32'd1);
      get_rsp("t2", 0);

      // 3: response held under back-pressure
      send_req(1'b0, 3'd5, '0, n);
      tick();
      tick();
      exp = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         check("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("t3_hold_data",  bus.rsp_data, exp);
         check("t3_hold_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      check("t3_rel_valid", 32'(bus.rsp_valid), 32'd0);
      check("t3_rel_idle",  32'(bus.req_ready), 32'd1);

      // 4: clear wins over a simultaneous request
      bus.clr_start = 1'b1;
      bus.clr_data  = 32'hA5A5A5A5;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 3'd2;
      #1;
      check("t4_ready_masked", 32'(bus.req_ready), 32'd0);
      tick();
      bus.clr_start = 1'b0;
      bus.clr_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         check("t4_busy",  32'(bus.clr_busy), 32'd1);
         check("t4_addr",  32'(mem_address),  32'(i));
         check("t4_wdata", mem_write_data,    32'hA5A5A5A5);
         check("t4_ready", 32'(bus.req_ready), 32'd0);
         tick();
      end
      check("t4_busy_end", 32'(bus.clr_busy), 32'd0);
      check("t4_we_end",   32'(mem_write_enable), 32'd0);
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'hA5A5A5A5;
      send_req(1'b0, 3'd2, '0, n);
      check("t4_req_wait", 32'(n), 32'd0);
      get_rsp("t4_pending", 0);
      for (int k = 0; k < DEPTH; k++) begin
         send_req(1'b0, ADDR_W'(k), '0, n);
         get_rsp("t4_read", 0);
      end

      // 5: reset in the middle of a clear
      for (int k = 0; k < DEPTH; k++) send_req(1'b1, ADDR_W'(k), 32'h0, n);
      tick();
      bus.clr_start = 1'b1;
      bus.clr_data  = 32'hFFFFFFFF;
      tick();
      bus.clr_start = 1'b0;
      repeat (3) tick();
      check("t5_addr3", 32'(mem_address), 32'd3);
      check("t5_we3",   32'(mem_write_enable), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_rst_we",    32'(mem_write_enable), 32'd0);
      check("t5_rst_addr",  32'(mem_address),      32'd0);
      check("t5_rst_wdata", mem_write_data,        32'd0);
      check("t5_rst_busy",  32'(bus.clr_busy),     32'd0);
      check("t5_rst_rdata", bus.rsp_data,          32'd0);
      check("t5_rst_valid", 32'(bus.rsp_valid),    32'd0);
      check("t5_rst_ready", 32'(bus.req_ready),    32'd1);
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k <= 3) ? 32'hFFFFFFFF : 32'h0;
      for (int k = 0; k < DEPTH; k++) begin
         send_req(1'b0, ADDR_W'(k), '0, n);
         get_rsp("t5_read", 0);
      end

      // 6: random traffic with the write-enable checker running
      for (int i = 0; i < 40; i++) begin
         ra  = ADDR_W'($urandom_range(0, DEPTH - 1));
         rnd = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            send_req(1'b1, ra, rnd, n);
         end else begin
            send_req(1'b0, ra, '0, n);
            get_rsp("t6_read", int'($urandom_range(0, 3)));
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
